// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int unsigned SYSID_ID_OFFSET = 0;
  localparam int unsigned SYSID_TS_OFFSET = 1;
  localparam int unsigned TMO_W           = 16;
  localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/sysid_read_timer.sv
// Stall counter for a single Avalon read; flags the stall cycle that exhausts the budget.
module sysid_read_timer
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = TMO_W'(cnt_q + TMO_W'(1));
    end
  end

  // High during the stall cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign expired_c_o = enable_i && !clear_i && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid slave's ID and timestamp words and
// reports whether they match the build-time values.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1288876136,
  parameter int unsigned ADDR_WIDTH         = 1,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic                  timeout,
  output logic [DATA_W-1:0]     captured_id,
  output logic [DATA_W-1:0]     captured_ts
);

  state_e                state_q, state_d;
  logic                  auto_pend_q, auto_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  id_ok_q, id_ok_d;
  logic                  ts_ok_q, ts_ok_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_W-1:0]     cap_id_q, cap_id_d;
  logic [DATA_W-1:0]     cap_ts_q, cap_ts_d;

  logic rd_accept_c;
  logic tmr_enable_c;
  logic tmr_clear_c;
  logic tmr_expired_c;
  logic launch_c;
  logic abort_c;

  assign rd_accept_c  = read_q & ~avm_waitrequest;
  assign tmr_enable_c = read_q & avm_waitrequest;

  sysid_read_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (tmr_clear_c),
    .enable_i    (tmr_enable_c),
    .expired_c_o (tmr_expired_c)
  );

  always_comb begin
    state_d     = state_q;
    auto_pend_d = auto_pend_q;
    addr_d      = addr_q;
    read_d      = read_q;
    busy_d      = busy_q;
    done_d      = done_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    cap_id_d    = cap_id_q;
    cap_ts_d    = cap_ts_q;
    tmr_clear_c = 1'b0;
    launch_c    = 1'b0;
    abort_c     = 1'b0;

    case (state_q)
      ST_IDLE: launch_c = start | auto_pend_q;
      ST_RD_ID: begin
        if (rd_accept_c) begin
          // Keep read asserted and step the address for a back-to-back timestamp read.
          cap_id_d    = avm_readdata;
          addr_d      = ADDR_WIDTH'(SYSID_TS_OFFSET);
          tmr_clear_c = 1'b1;
          state_d     = ST_RD_TS;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_RD_TS: begin
        if (rd_accept_c) begin
          cap_ts_d    = avm_readdata;
          read_d      = 1'b0;
          tmr_clear_c = 1'b1;
          state_d     = ST_CHECK;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_CHECK: begin
        id_ok_d = (cap_id_q == EXPECTED_ID);
        ts_ok_d = (cap_ts_q == EXPECTED_TIMESTAMP);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: launch_c = start;
      default: state_d = ST_IDLE;
    endcase

    // Stalled slave: give up on the read; unread words keep their old captures.
    if (abort_c) begin
      read_d    = 1'b0;
      timeout_d = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_DONE;
    end

    if (launch_c) begin
      auto_pend_d = 1'b0;
      read_d      = 1'b1;
      addr_d      = ADDR_WIDTH'(SYSID_ID_OFFSET);
      busy_d      = 1'b1;
      done_d      = 1'b0;
      id_ok_d     = 1'b0;
      ts_ok_d     = 1'b0;
      timeout_d   = 1'b0;
      tmr_clear_c = 1'b1;
      state_d     = ST_RD_ID;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      auto_pend_q <= AUTO_START;
      addr_q      <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cap_id_q    <= '0;
      cap_ts_q    <= '0;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= auto_pend_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      timeout_q   <= timeout_d;
      cap_id_q    <= cap_id_d;
      cap_ts_q    <= cap_ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: randomized slave stalls and data against a latency/outcome model.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1288876136;
  localparam int          T      = 4;
  localparam int          STUCK  = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [0:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;

  sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .ADDR_WIDTH         (1),
    .TIMEOUT_CYCLES     (T),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts)
  );

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] cap_id;
    logic [31:0] cap_ts;
    int          done_cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] m_cap_id = '0;
  logic [31:0] m_cap_ts = '0;
  int          plan_stall[2];
  logic [31:0] plan_data[2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Outcome and done cycle of one check launched in cycle n, from the stall/data plan.
  function automatic exp_t model(input int s0, input int s1, input logic [31:0] d0,
                                 input logic [31:0] d1, input int n);
    exp_t e;
    e.id_ok  = 1'b0;
    e.ts_ok  = 1'b0;
    e.tmo    = 1'b0;
    e.cap_id = m_cap_id;
    e.cap_ts = m_cap_ts;
    if (s0 >= T) begin
      e.tmo      = 1'b1;
      e.done_cyc = n + T + 1;
    end else begin
      e.cap_id = d0;
      if (s1 >= T) begin
        e.tmo      = 1'b1;
        e.done_cyc = n + s0 + 1 + T + 1;
      end else begin
        e.cap_ts   = d1;
        e.id_ok    = (d0 == EXP_ID);
        e.ts_ok    = (d1 == EXP_TS);
        e.done_cyc = n + s0 + s1 + 4;
      end
    end
    m_cap_id = e.cap_id;
    m_cap_ts = e.cap_ts;
    return e;
  endfunction

  // Slave: stalls each read per the plan, returns junk whenever data is not valid.
  initial begin : slave
    int scnt;
    scnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (avm_read) begin
        if (scnt < plan_stall[avm_address]) begin
          avm_waitrequest = 1'b1;
          avm_readdata    = $urandom;
          scnt++;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata    = plan_data[avm_address];
          scnt            = 0;
        end
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = $urandom;
        scnt            = 0;
      end
    end
  end

  initial begin : monitor
    logic       p_read, p_wr, p_rst, p_done;
    logic [0:0] p_addr;
    exp_t       e;
    p_read = 1'b0;
    p_wr   = 1'b0;
    p_rst  = 1'b1;
    p_done = 1'b0;
    p_addr = '0;
    forever begin
      @(negedge clock);
      if (p_read && p_wr && !p_rst) chk("addr_hold", 64'(avm_address), 64'(p_addr));
      if (done && !p_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("id_ok", 64'(id_ok), 64'(e.id_ok));
          chk("ts_ok", 64'(ts_ok), 64'(e.ts_ok));
          chk("timeout", 64'(timeout), 64'(e.tmo));
          chk("captured_id", 64'(captured_id), 64'(e.cap_id));
          chk("captured_ts", 64'(captured_ts), 64'(e.cap_ts));
          chk("busy_in_done", 64'(busy), 64'(0));
        end
      end
      p_read = avm_read;
      p_wr   = avm_waitrequest;
      p_addr = avm_address;
      p_rst  = reset;
      p_done = done;
    end
  end

  task automatic set_plan(input int s0, input int s1, input logic [31:0] d0, input logic [31:0] d1);
    plan_stall[0] = s0;
    plan_stall[1] = s1;
    plan_data[0]  = d0;
    plan_data[1]  = d1;
  endtask

  task automatic wait_done(input int dc);
    while (cyc < dc + 1) tick();
    chk("done_seen", 64'(exp_q.size()), 64'(0));
  endtask

  // Launch from DONE; poke_off>0 pulses start that many cycles in, -1 picks a random busy cycle.
  task automatic run_check(input int s0, input int s1, input logic [31:0] d0,
                           input logic [31:0] d1, input int poke_off);
    exp_t e;
    int   n, p;
    set_plan(s0, s1, d0, d1);
    n = cyc;
    start = 1'b1;
    e = model(s0, s1, d0, d1, n);
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    chk("launch_done_clr", 64'(done), 64'(0));
    chk("launch_status_clr", 64'({timeout, id_ok, ts_ok}), 64'(0));
    chk("launch_busy", 64'(busy), 64'(1));
    chk("launch_read", 64'({avm_read, avm_address}), 64'(2'b10));
    if (poke_off != 0) begin
      p = (poke_off > 0) ? n + poke_off : n + $urandom_range(1, e.done_cyc - n - 1);
      while (cyc < p) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(e.done_cyc);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    exp_t        e;
    int          n, s0, s1;
    logic [31:0] d0, d1;

    set_plan(0, 0, EXP_ID, EXP_TS);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl", 64'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 64'(0));
    chk("rst_cap", {captured_id, captured_ts}, 64'(0));

    // Auto-start out of reset with a zero-wait slave.
    n = cyc;
    reset = 1'b0;
    e = model(0, 0, EXP_ID, EXP_TS, n);
    exp_q.push_back(e);
    tick();
    chk("auto_rd_id", 64'({avm_read, avm_address}), 64'(2'b10));
    tick();
    chk("auto_rd_ts", 64'({avm_read, avm_address}), 64'(2'b11));
    tick();
    chk("auto_rd_end", 64'(avm_read), 64'(0));
    wait_done(e.done_cyc);

    run_check(0, 0, EXP_ID, EXP_TS + 32'd1, 0);
    run_check(3, 3, EXP_ID, EXP_TS, 0);
    run_check(STUCK, 0, 32'h1234_5678, EXP_TS, 0);
    run_check(T - 1, T - 1, EXP_ID, EXP_TS, 0);
    run_check(1, STUCK, 32'hdead_beef, EXP_TS, 0);
    run_check(0, 2, EXP_ID, EXP_TS, 2);

    // Reset while stalled on the timestamp read, then auto-restart.
    set_plan(0, STUCK, EXP_ID, EXP_TS);
    n = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stall_ts", 64'({avm_read, avm_address}), 64'(2'b11));
    reset = 1'b1;
    exp_q.delete();
    m_cap_id = '0;
    m_cap_ts = '0;
    tick();
    chk("midrst_ctrl", 64'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 64'(0));
    chk("midrst_cap", {captured_id, captured_ts}, 64'(0));
    reset = 1'b0;
    set_plan(0, 0, EXP_ID, EXP_TS);
    e = model(0, 0, EXP_ID, EXP_TS, cyc);
    exp_q.push_back(e);
    wait_done(e.done_cyc);

    for (int i = 0; i < 40; i++) begin
      s0 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, T - 1) : $urandom_range(T, T + 2);
      s1 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, T - 1) : $urandom_range(T, T + 2);
      d0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      d1 = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
      run_check(s0, s1, d0, d1, ($urandom_range(0, 1) == 1) ? -1 : 0);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
